// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core.
// Sequences the shared ALU, the memory port, the register file and the immediate
// generator over several cycles per instruction. It also handles memory wait
// states, branch resolution and detection of illegal instructions.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter int         SEL_EXT_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          Ins,
    input  logic                 mem_ready,
    input  logic                 Zero,
    input  logic                 Lt,
    input  logic                 Ltu,
    output logic [SEL_EXT_W-1:0] sel_ext,
    output logic                 PCUpdate,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ResultSrc,
    output logic                 illegal
);

    // FSM state encoding
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_AUIPC    = 4'd13;
    localparam logic [3:0] S_ILLEGAL  = 4'd14;

    // RV32I major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Immediate formats understood by the immediate generator
    localparam logic [SEL_EXT_W-1:0] SEL_I = SEL_EXT_W'(0);
    localparam logic [SEL_EXT_W-1:0] SEL_S = SEL_EXT_W'(1);
    localparam logic [SEL_EXT_W-1:0] SEL_B = SEL_EXT_W'(2);
    localparam logic [SEL_EXT_W-1:0] SEL_U = SEL_EXT_W'(3);
    localparam logic [SEL_EXT_W-1:0] SEL_J = SEL_EXT_W'(4);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_br_taken;
    logic       w_br_valid;
    logic       w_pc_update;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_unused;

    assign w_opcode = Ins[6:0];
    assign w_funct3 = Ins[14:12];
    // Only opcode and funct3 steer this block; the rest of Ins feeds the datapath.
    assign w_unused = ^{Ins[31:15], Ins[11:7]};

    // Immediate format follows the opcode in every state
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sel_ext = SEL_I;
        case (w_opcode)
            OP_STORE:          sel_ext = SEL_S;
            OP_BRANCH:         sel_ext = SEL_B;
            OP_LUI, OP_AUIPC:  sel_ext = SEL_U;
            OP_JAL:            sel_ext = SEL_J;
            default:           sel_ext = SEL_I;
        endcase
    end

    // Branch condition from funct3 and the ALU compare flags; 010/011 are not branches
    always_comb begin
        w_br_taken = 1'b0;
        w_br_valid = 1'b1;
        case (w_funct3)
            3'b000:  w_br_taken = Zero;
            3'b001:  w_br_taken = ~Zero;
            3'b100:  w_br_taken = Lt;
            3'b101:  w_br_taken = ~Lt;
            3'b110:  w_br_taken = Ltu;
            3'b111:  w_br_taken = ~Ltu;
            default: w_br_valid = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECR;
                    OP_ITYPE:          w_next_state = S_EXECI;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_JALR:           w_next_state = S_JALR;
                    OP_LUI:            w_next_state = S_LUI;
                    OP_AUIPC:          w_next_state = S_AUIPC;
                    default:           w_next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next_state = (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = w_br_valid ? S_FETCH : S_ILLEGAL;
            S_JAL:      w_next_state = S_ALUWB;
            S_JALR:     w_next_state = S_JAL;
            S_LUI:      w_next_state = S_FETCH;
            S_AUIPC:    w_next_state = S_ALUWB;
            S_ILLEGAL:  w_next_state = S_ILLEGAL;
            default:    w_next_state = S_ILLEGAL;
        endcase
    end

    // State register; reset aborts any instruction and restarts at fetch
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
        if (rst) r_state <= RESET_STATE;
        else     r_state <= w_next_state;
    end

    // Per-state datapath controls and raw strobes; anything not driven stays 0
    always_comb begin
        w_pc_update = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        ResultSrc   = 2'b00;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_ir_write  = mem_ready;
                w_pc_update = mem_ready;
            end
            S_DECODE: begin
                // OldPC + imm: branch / JAL target parked in ALUOut
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR, S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 2'b10;
                ALUOp       = 2'b01;
                w_pc_update = w_br_valid & w_br_taken;
            end
            S_JAL: begin
                // PC takes the target in ALUOut while the ALU forms the link OldPC + 4
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            S_LUI: begin
                ResultSrc   = 2'b11;
                w_reg_write = 1'b1;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

    // Architectural write strobes are held off for as long as reset is asserted
    assign PCUpdate = w_pc_update & ~rst;
    assign IRWrite  = w_ir_write  & ~rst;
    assign MemWrite = w_mem_write & ~rst;
    assign RegWrite = w_reg_write & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks instruction sequences cycle by
// cycle and compares every control output against hand-derived vectors.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] Ins;
    logic        mem_ready;
    logic        Zero;
    logic        Lt;
    logic        Ltu;
    logic [2:0]  sel_ext;
    logic        PCUpdate;
    logic        IRWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        RegWrite;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic [1:0]  ResultSrc;
    logic        illegal;
    logic [13:0] ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .Ins       (Ins),
        .mem_ready (mem_ready),
        .Zero      (Zero),
        .Lt        (Lt),
        .Ltu       (Ltu),
        .sel_ext   (sel_ext),
        .PCUpdate  (PCUpdate),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ResultSrc (ResultSrc),
        .illegal   (illegal)
    );

    // {PCUpdate, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal}
    assign ctrl = {PCUpdate, IRWrite, AdrSrc, MemWrite, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal};

    localparam logic [13:0] E_IDLE    = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0}; // fetch, no strobes
    localparam logic [13:0] E_FETCH   = {5'b11000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
    localparam logic [13:0] E_DECODE  = {5'b00000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [13:0] E_EXECR   = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [13:0] E_EXECI   = {5'b00000, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
    localparam logic [13:0] E_ALUWB   = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [13:0] E_MEMADR  = {5'b00000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [13:0] E_MEMRD   = {5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [13:0] E_MEMWB   = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
    localparam logic [13:0] E_MEMWR   = {5'b00110, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [13:0] E_BR_T    = {5'b10000, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [13:0] E_BR_N    = {5'b00000, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [13:0] E_JAL     = {5'b10000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [13:0] E_JALR    = {5'b00000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [13:0] E_LUI     = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0};
    localparam logic [13:0] E_AUIPC   = {5'b00000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [13:0] E_ILLEGAL = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

    localparam logic [2:0] SI = 3'd0, SS = 3'd1, SB = 3'd2, SU = 3'd3, SJ = 3'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply mem_ready for one cycle, compare outputs at the falling edge, then advance past the rising edge
    task automatic step(input string tag, input logic mr, input logic [13:0] exp_ctrl, input logic [2:0] exp_sel);
        mem_ready = mr;
        @(negedge clk);
        check({tag, "/ctrl"}, 32'(ctrl), 32'(exp_ctrl));
        check({tag, "/sel"}, 32'(sel_ext), 32'(exp_sel));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; Ins = 32'h002081B3; mem_ready = 1'b1;
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;

        // Reset held across an edge: fetch state, strobes forced low even with mem_ready=1
        @(negedge clk);
        check("reset/ctrl", 32'(ctrl), 32'(E_IDLE));
        @(posedge clk); #1;
        check("reset_hold/ctrl", 32'(ctrl), 32'(E_IDLE));
        rst = 1'b0;

        // add x3,x1,x2
        step("add.F",  1'b1, E_FETCH,  SI);
        step("add.D",  1'b1, E_DECODE, SI);
        step("add.EX", 1'b1, E_EXECR,  SI);
        step("add.WB", 1'b1, E_ALUWB,  SI);

        // lw x5,8(x1) with two wait cycles in MEMREAD
        Ins = 32'h0080A283;
        step("lw.F",   1'b1, E_FETCH,  SI);
        step("lw.D",   1'b1, E_DECODE, SI);
        step("lw.MA",  1'b1, E_MEMADR, SI);
        step("lw.MR0", 1'b0, E_MEMRD,  SI);
        step("lw.MR1", 1'b0, E_MEMRD,  SI);
        step("lw.MR2", 1'b1, E_MEMRD,  SI);
        step("lw.WB",  1'b1, E_MEMWB,  SI);

        // sw x2,4(x1) with one wait cycle on the store
        Ins = 32'h0020A223;
        step("sw.F",   1'b1, E_FETCH,  SS);
        step("sw.D",   1'b1, E_DECODE, SS);
        step("sw.MA",  1'b1, E_MEMADR, SS);
        step("sw.MW0", 1'b0, E_MEMWR,  SS);
        step("sw.MW1", 1'b1, E_MEMWR,  SS);

        // beq taken, beq not taken, bltu taken, bge not taken
        Ins = 32'h00208463; Zero = 1'b1;
        step("beq1.F", 1'b1, E_FETCH,  SB);
        step("beq1.D", 1'b1, E_DECODE, SB);
        step("beq1.B", 1'b1, E_BR_T,   SB);
        Zero = 1'b0;
        step("beq0.F", 1'b1, E_FETCH,  SB);
        step("beq0.D", 1'b1, E_DECODE, SB);
        step("beq0.B", 1'b1, E_BR_N,   SB);
        Ins = 32'h0020E463; Ltu = 1'b1;
        step("bltu.F", 1'b1, E_FETCH,  SB);
        step("bltu.D", 1'b1, E_DECODE, SB);
        step("bltu.B", 1'b1, E_BR_T,   SB);
        Ins = 32'h0020D463; Ltu = 1'b0; Lt = 1'b1;
        step("bge.F",  1'b1, E_FETCH,  SB);
        step("bge.D",  1'b1, E_DECODE, SB);
        step("bge.B",  1'b1, E_BR_N,   SB);
        Lt = 1'b0;

        // jalr x1,0(x5)
        Ins = 32'h000280E7;
        step("jalr.F",  1'b1, E_FETCH,  SI);
        step("jalr.D",  1'b1, E_DECODE, SI);
        step("jalr.JR", 1'b1, E_JALR,   SI);
        step("jalr.J",  1'b1, E_JAL,    SI);
        step("jalr.WB", 1'b1, E_ALUWB,  SI);

        // jal x1,8
        Ins = 32'h008000EF;
        step("jal.F",  1'b1, E_FETCH,  SJ);
        step("jal.D",  1'b1, E_DECODE, SJ);
        step("jal.J",  1'b1, E_JAL,    SJ);
        step("jal.WB", 1'b1, E_ALUWB,  SJ);

        // lui x1,0x12345
        Ins = 32'h123450B7;
        step("lui.F", 1'b1, E_FETCH,  SU);
        step("lui.D", 1'b1, E_DECODE, SU);
        step("lui.L", 1'b1, E_LUI,    SU);

        // auipc x1,0
        Ins = 32'h00000097;
        step("auipc.F",  1'b1, E_FETCH,  SU);
        step("auipc.D",  1'b1, E_DECODE, SU);
        step("auipc.A",  1'b1, E_AUIPC,  SU);
        step("auipc.WB", 1'b1, E_ALUWB,  SU);

        // addi x1,x1,1 after a one-cycle fetch wait
        Ins = 32'h00108093;
        step("addi.FW", 1'b0, E_IDLE,   SI);
        step("addi.F",  1'b1, E_FETCH,  SI);
        step("addi.D",  1'b1, E_DECODE, SI);
        step("addi.EX", 1'b1, E_EXECI,  SI);
        step("addi.WB", 1'b1, E_ALUWB,  SI);

        // Illegal opcode: flag sticks, no strobes, mem_ready ignored
        Ins = 32'h0000007F;
        step("ill.F", 1'b1, E_FETCH,  SI);
        step("ill.D", 1'b1, E_DECODE, SI);
        for (int i = 0; i < 10; i++) step($sformatf("ill.H%0d", i), 1'b1, E_ILLEGAL, SI);

        // Reset clears the illegal flag
        rst = 1'b1;
        #1;
        check("ill_rst/illegal", 32'(illegal), 32'd0);
        check("ill_rst/ctrl", 32'(ctrl), 32'(E_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;

        // Store aborted by async reset mid-MEMWRITE
        Ins = 32'h0020A223;
        step("swr.F",  1'b1, E_FETCH,  SS);
        step("swr.D",  1'b1, E_DECODE, SS);
        step("swr.MA", 1'b1, E_MEMADR, SS);
        mem_ready = 1'b0;
        #2;
        check("swr.MW/ctrl", 32'(ctrl), 32'(E_MEMWR));
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("swr.rst/memwrite", 32'(MemWrite), 32'd0);
        check("swr.rst/ctrl", 32'(ctrl), 32'(E_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        Ins = 32'h002081B3;
        step("post.F", 1'b1, E_FETCH,  SI);
        step("post.D", 1'b1, E_DECODE, SI);

        // Branch with reserved funct3 010: no PC update, then illegal
        Ins = 32'h0020A463; Zero = 1'b1;
        step("post.EX", 1'b1, E_EXECR,  SB);
        step("post.WB", 1'b1, E_ALUWB,  SB);
        step("bbad.F",  1'b1, E_FETCH,  SB);
        step("bbad.D",  1'b1, E_DECODE, SB);
        step("bbad.B",  1'b1, E_BR_N,   SB);
        step("bbad.I",  1'b1, E_ILLEGAL, SB);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core. It sequences the shared ALU, memory port, register file and immediate generator over several cycles per instruction. The immediate generator select (sel_ext) is decoded from the latched instruction's opcode. It also handles memory wait states, branch resolution and detection of illegal opcodes.

Parameters:
RESET_STATE, 4'd0 (FETCH), state entered on reset
SEL_EXT_W, 3, width of immediate-select output

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
Ins  in  32  latched instruction register contents (opcode [6:0], funct3 [14:12])
mem_ready  in  1  memory port completes access this cycle
Zero  in  1  ALU result == 0
Lt  in  1  signed rs1 < rs2 (ALU compare)
Ltu  in  1  unsigned rs1 < rs2
sel_ext  out  3  immediate format: I=0, S=1, B=2, U=3, J=4
PCUpdate  out  1  PC register write enable
IRWrite  out  1  instruction/OldPC register write enable
AdrSrc  out  1  memory address: 0=PC, 1=Result
MemWrite  out  1  data store strobe
RegWrite  out  1  register file write enable
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 reg
ALUSrcB  out  2  00=rs2 reg, 01=ImmExt, 10=const 4
ALUOp  out  2  00=add, 01=subtract/compare, 10=decode funct3/funct7
ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALU result, 11=ImmExt
illegal  out  1  sticky illegal-instruction flag

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL. 4-bit state register.
- Reset (async): state=FETCH. illegal=0. While rst is high, PCUpdate, IRWrite, MemWrite and RegWrite are forced to 0.
- All outputs are combinational from the state, Ins, mem_ready and the flags. Any output not listed for a state is 0.
- sel_ext is decoded from opcode in every state:
  - 0100011 → S
  - 1100011 → B
  - 0110111 or 0010111 → U
  - 1101111 → J
  - all others → I
- FETCH: AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=mem_ready. Stay in FETCH until mem_ready, then go to DECODE. Zero-wait fetch takes 1 cycle.
- DECODE: A=01, B=01, ALUOp=00. This computes the branch/JAL target into ALUOut. Next state by opcode:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - else → ILLEGAL
- MEMADR: A=10, B=01, ALUOp=00. Go to MEMREAD if opcode is load, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays high until the mem_ready cycle inclusive, then FETCH.
- EXECR: A=10, B=00, ALUOp=10, then ALUWB.
- EXECI: A=10, B=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: A=10, B=00, ALUOp=01, ResultSrc=00. PCUpdate=taken, then FETCH. taken by funct3:
  - 000 Zero; 001 !Zero
  - 100 Lt; 101 !Lt
  - 110 Ltu; 111 !Ltu
  - funct3 010/011 → ILLEGAL, with PCUpdate=0.
- JAL: A=01, B=10, ALUOp=00, ResultSrc=00, PCUpdate=1. PC takes the ALUOut target; the ALU computes PC+4 (OldPC + 4). Then ALUWB, which writes rd with the link value.
- JALR: A=10, B=01, ALUOp=00 computes rs1+imm into ALUOut, then JAL (reused). Bit 0 of the target is cleared by the PC write logic outside this block.
- LUI: ResultSrc=11, RegWrite=1, then FETCH.
- AUIPC: A=01, B=01, ALUOp=00, then ALUWB.
- ILLEGAL: illegal=1 and sticky. State holds until rst; no strobes are asserted.
- Cycle counts (zero-wait memory):
  - R/I-type, AUIPC: 4
  - load: 5
  - store: 4
  - branch, LUI: 3
  - JAL: 4
  - JALR: 5
- mem_ready is ignored in states that do not access memory.
- Reset asserted mid-instruction aborts it immediately. No partial write strobe survives, and FETCH resumes on release.

Test Plan:
- add x3,x1,x2 (Ins=0x002081B3), mem_ready=1 → FETCH, DECODE, EXECR (ALUOp=10, B=00), ALUWB (RegWrite=1), FETCH; sel_ext=0; 4 cycles.
- lw x5,8(x1) (0x0080A283) with mem_ready low 2 cycles in MEMREAD → AdrSrc=1 held 3 cycles; MEMWB ResultSrc=01, RegWrite=1; total 7 cycles.
- sw x2,4(x1) (0x0020A223) → sel_ext=1; MemWrite=1 in MEMWRITE only; RegWrite never 1.
- beq (0x00208463), Zero=1 → BRANCH PCUpdate=1, sel_ext=2. Repeat with Zero=0 → PCUpdate=0. Repeat with bltu, Ltu=1 → PCUpdate=1.
- jalr x1,0(x5) (0x000280E7) → DECODE, JALR, JAL (PCUpdate=1), ALUWB (RegWrite=1); 5 cycles.
- Opcode 0x7F → ILLEGAL, illegal=1 held for 10 cycles. Async rst pulse in mid-MEMWRITE with MemWrite=1 → MemWrite drops the same cycle, state=FETCH, illegal=0.
